// File: rtl/lstm_input_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lstm_input_sequencer_pkg
//   Shared sizing constants and FSM state encoding for the LSTM input
//   sequencer and its address generator.
//   No ports: imported with "import lstm_input_sequencer_pkg::*;".
// -----------------------------------------------------------------------------
package lstm_input_sequencer_pkg;

    localparam int WIDTH            = 32;
    localparam int NUM              = 45;
    localparam int NUM_ITERATIONS   = 8;
    localparam int NUM_SAMPLES      = 2;
    localparam int WORDS_PER_SAMPLE = NUM * NUM_ITERATIONS;
    localparam int ROM_DEPTH        = WORDS_PER_SAMPLE * NUM_SAMPLES;

    // FSM state encoding, kept as plain constants for legacy tool flows
    localparam int         STATE_W      = 2;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_STREAM    = 2'd1;
    localparam logic [1:0] ST_STEP_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/lstm_input_sequencer_addr_gen.sv
// -----------------------------------------------------------------------------
// lstm_seq_addr_gen
//   Feature/timestep counters, per-sample base register and the ROM address
//   adder (base + step*NUM + feat) for the LSTM input sequencer.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          return counters to zero (abort)
//   load_base    capture base = sel_in*NUM*NUM_ITERATIONS and zero the counters
//   sel_in       sample index used by load_base
//   step_inc     advance to the next timestep, feature back to 0
//   feat_inc     advance to the next feature word
//   mem_addr     ROM address for the current feature/timestep
//   feat, step   current counter values
//   last_feat    feat is the last word of a timestep
//   last_step    step is the last timestep of a sample
// -----------------------------------------------------------------------------
module lstm_seq_addr_gen #(
    parameter int WIDTH          = 32,
    parameter int NUM            = 45,
    parameter int NUM_ITERATIONS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_base,
    input  logic [WIDTH-1:0] sel_in,
    input  logic             step_inc,
    input  logic             feat_inc,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] feat,
    output logic [WIDTH-1:0] step,
    output logic             last_feat,
    output logic             last_step
);

    localparam logic [WIDTH-1:0] NUM_W       = WIDTH'(NUM);
    localparam logic [WIDTH-1:0] WPS_W       = WIDTH'(NUM * NUM_ITERATIONS);
    localparam logic [WIDTH-1:0] LAST_FEAT_W = WIDTH'(NUM - 1);
    localparam logic [WIDTH-1:0] LAST_STEP_W = WIDTH'(NUM_ITERATIONS - 1);
    localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W      = WIDTH'(0);

    logic [WIDTH-1:0] feat_q, feat_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] base_q, base_d;

    // Next-state for the counters and base; clear has priority over loading
    always_comb begin
        feat_d = feat_q;
        step_d = step_q;
        base_d = base_q;
        if (clr) begin
            feat_d = ZERO_W;
            step_d = ZERO_W;
        end else if (load_base) begin
            base_d = sel_in * WPS_W;
            feat_d = ZERO_W;
            step_d = ZERO_W;
        end else if (step_inc) begin
            step_d = step_q + ONE_W;
            feat_d = ZERO_W;
        end else if (feat_inc) begin
            feat_d = feat_q + ONE_W;
        end else begin
            feat_d = feat_q;
        end
    end

    // Counter and base registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q <= ZERO_W;
            step_q <= ZERO_W;
            base_q <= ZERO_W;
        end else begin
            feat_q <= feat_d;
            step_q <= step_d;
            base_q <= base_d;
        end
    end

    // Address is derived only from registers, so it is stable for a full cycle
    assign mem_addr  = base_q + (step_q * NUM_W) + feat_q;
    assign feat      = feat_q;
    assign step      = step_q;
    assign last_feat = (feat_q == LAST_FEAT_W);
    assign last_step = (step_q == LAST_STEP_W);

endmodule

// File: rtl/lstm_input_sequencer.sv
// -----------------------------------------------------------------------------
// lstm_input_sequencer
//   Walks the input-vector ROM for one sample and streams its feature words,
//   one timestep at a time, on a valid/ready interface. After the last word of
//   each timestep it waits for step_ack before fetching the next timestep.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         1-cycle request to stream the sample chosen by sample_sel
//   sample_sel    sample index (start ignored when out of range)
//   abort         synchronous return to IDLE, highest priority after reset
//   step_ack      cell finished with the current timestep
//   mem_addr      ROM address (combinational ROM read)
//   mem_data      ROM read data, forwarded unmodified
//   x_data        feature word; x_feat/x_step/x_last_feat/x_last_step tag it
//   x_valid       word valid; x_ready consumer accepts it
//   busy          not IDLE
//   done          1-cycle pulse when the whole sample is acknowledged
// -----------------------------------------------------------------------------
module lstm_input_sequencer
    import lstm_input_sequencer_pkg::*;
#(
    parameter int WIDTH          = lstm_input_sequencer_pkg::WIDTH,
    parameter int NUM            = lstm_input_sequencer_pkg::NUM,
    parameter int NUM_ITERATIONS = lstm_input_sequencer_pkg::NUM_ITERATIONS,
    parameter int NUM_SAMPLES    = lstm_input_sequencer_pkg::NUM_SAMPLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] sample_sel,
    input  logic             abort,
    input  logic             step_ack,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] x_data,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [WIDTH-1:0] x_feat,
    output logic [WIDTH-1:0] x_step,
    output logic             x_last_feat,
    output logic             x_last_step,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] NUM_SAMPLES_W = WIDTH'(NUM_SAMPLES);
    localparam logic [WIDTH-1:0] ZERO_W        = WIDTH'(0);

    logic [STATE_W-1:0] state_q, state_d;
    logic               fetch_done_q, fetch_done_d;
    logic [WIDTH-1:0]   x_data_q, x_data_d;
    logic               x_valid_q, x_valid_d;
    logic [WIDTH-1:0]   x_feat_q, x_feat_d;
    logic [WIDTH-1:0]   x_step_q, x_step_d;
    logic               x_last_feat_q, x_last_feat_d;
    logic               x_last_step_q, x_last_step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               clr_s;
    logic               load_base_s;
    logic               step_inc_s;
    logic               feat_inc_s;
    logic [WIDTH-1:0]   feat_s;
    logic [WIDTH-1:0]   step_s;
    logic               last_feat_s;
    logic               last_step_s;

    lstm_seq_addr_gen #(
        .WIDTH          (WIDTH),
        .NUM            (NUM),
        .NUM_ITERATIONS (NUM_ITERATIONS)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .load_base (load_base_s),
        .sel_in    (sample_sel),
        .step_inc  (step_inc_s),
        .feat_inc  (feat_inc_s),
        .mem_addr  (mem_addr),
        .feat      (feat_s),
        .step      (step_s),
        .last_feat (last_feat_s),
        .last_step (last_step_s)
    );

    // FSM, output register and counter control
    always_comb begin
        state_d       = state_q;
        fetch_done_d  = fetch_done_q;
        x_data_d      = x_data_q;
        x_valid_d     = x_valid_q;
        x_feat_d      = x_feat_q;
        x_step_d      = x_step_q;
        x_last_feat_d = x_last_feat_q;
        x_last_step_d = x_last_step_q;
        clr_s         = 1'b0;
        load_base_s   = 1'b0;
        step_inc_s    = 1'b0;
        feat_inc_s    = 1'b0;

        if (abort) begin
            state_d      = ST_IDLE;
            x_valid_d    = 1'b0;
            fetch_done_d = 1'b0;
            clr_s        = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // out-of-range sample indices are silently refused
                    if (start && (sample_sel < NUM_SAMPLES_W)) begin
                        state_d      = ST_STREAM;
                        fetch_done_d = 1'b0;
                        load_base_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (!fetch_done_q && (!x_valid_q || x_ready)) begin
                        // output slot free (or being freed): take the ROM word
                        x_data_d      = mem_data;
                        x_valid_d     = 1'b1;
                        x_feat_d      = feat_s;
                        x_step_d      = step_s;
                        x_last_feat_d = last_feat_s;
                        x_last_step_d = last_step_s;
                        if (last_feat_s) begin
                            fetch_done_d = 1'b1;
                        end else begin
                            feat_inc_s = 1'b1;
                        end
                    end else if (fetch_done_q && x_valid_q && x_ready) begin
                        // last word of the timestep has been taken
                        x_valid_d = 1'b0;
                        state_d   = ST_STEP_WAIT;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                ST_STEP_WAIT: begin
                    if (step_ack) begin
                        if (last_step_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d      = ST_STREAM;
                            fetch_done_d = 1'b0;
                            step_inc_s   = 1'b1;
                        end
                    end else begin
                        state_d = ST_STEP_WAIT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d      = ST_IDLE;
                    x_valid_d    = 1'b0;
                    fetch_done_d = 1'b0;
                    clr_s        = 1'b1;
                end
            endcase
        end

        // status outputs are registered copies of the next state
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fetch_done_q  <= 1'b0;
            x_data_q      <= ZERO_W;
            x_valid_q     <= 1'b0;
            x_feat_q      <= ZERO_W;
            x_step_q      <= ZERO_W;
            x_last_feat_q <= 1'b0;
            x_last_step_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_done_q  <= fetch_done_d;
            x_data_q      <= x_data_d;
            x_valid_q     <= x_valid_d;
            x_feat_q      <= x_feat_d;
            x_step_q      <= x_step_d;
            x_last_feat_q <= x_last_feat_d;
            x_last_step_q <= x_last_step_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign x_data      = x_data_q;
    assign x_valid     = x_valid_q;
    assign x_feat      = x_feat_q;
    assign x_step      = x_step_q;
    assign x_last_feat = x_last_feat_q;
    assign x_last_step = x_last_step_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_lstm_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lstm_input_sequencer
//   Self-checking bench. The ROM holds word[a] = a. The expected stream for a
//   sample is derived from its word index: value = sel*360 + i, feature i%45,
//   timestep i/45. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lstm_input_sequencer;
    import lstm_input_sequencer_pkg::*;

    localparam int N   = 45;
    localparam int T   = 8;
    localparam int WPS = N * T;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] sample_sel;
    logic        abort;
    logic        step_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_feat;
    logic [31:0] x_step;
    logic        x_last_feat;
    logic        x_last_step;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_data = (mem_addr < 32'(ROM_DEPTH)) ? mem_addr : 32'hDEAD_BEEF;

    lstm_input_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sample_sel  (sample_sel),
        .abort       (abort),
        .step_ack    (step_ack),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .x_data      (x_data),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_feat      (x_feat),
        .x_step      (x_step),
        .x_last_feat (x_last_feat),
        .x_last_step (x_last_step),
        .busy        (busy),
        .done        (done)
    );

    // Runs one sample from start. mode: 0 ready always high, 1 ready toggles in
    // step 0, 2 spurious start/step_ack during streaming, 3 abort at step 3
    // feat 20, 4 async reset at step 5 feat 10.
    task automatic drive_sample(input int sel, input int mode, output int words, output int dones);
        int idx, ack_cd, acks, ev, ef, es;
        bit stalled, fin, got_done;
        logic [31:0] h_data, h_feat, h_step;
        idx = 0; ack_cd = 0; acks = 0; stalled = 1'b0; fin = 1'b0; got_done = 1'b0;
        dones = 0; h_data = 32'd0; h_feat = 32'd0; h_step = 32'd0;
        sample_sel = 32'(sel); start = 1'b1; x_ready = 1'b1; step_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (x_valid !== 1'b0 || busy !== 1'b1 || mem_addr !== 32'(sel * WPS)) begin
            errors++;
            $display("FAIL latency_n1 got valid=%0b busy=%0b addr=%0d exp valid=0 busy=1 addr=%0d",
                     x_valid, busy, mem_addr, sel * WPS);
        end
        @(negedge clk);
        checks++;
        if (x_valid !== 1'b1 || x_data !== 32'(sel * WPS)) begin
            errors++;
            $display("FAIL latency_n2 got valid=%0b data=%0d exp valid=1 data=%0d", x_valid, x_data, sel * WPS);
        end
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            x_ready  = (mode == 1 && idx < N) ? (cyc % 2 == 0) : 1'b1;
            step_ack = 1'b0;
            start    = 1'b0;
            if (mode == 2 && x_valid === 1'b1 && x_last_feat === 1'b0) begin
                step_ack   = ($urandom_range(0, 2) == 0);
                start      = ($urandom_range(0, 2) == 0);
                sample_sel = 32'(sel ^ 1);
            end
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin
                    step_ack = 1'b1;
                    acks++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                got_done = 1'b1;
                checks++;
                if (idx != WPS || acks != T) begin
                    errors++;
                    $display("FAIL done_timing got words=%0d acks=%0d exp words=%0d acks=%0d", idx, acks, WPS, T);
                end
                fin = 1'b1;
            end
            if (mode == 0 && idx % N != 0 && idx < WPS) begin
                checks++;
                if (x_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL no_bubble got valid=%0b exp 1 at word %0d", x_valid, idx);
                end
            end
            if (x_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (x_data !== h_data || x_feat !== h_feat || x_step !== h_step) begin
                        errors++;
                        $display("FAIL stall_hold got %0d/%0d/%0d exp %0d/%0d/%0d",
                                 x_data, x_feat, x_step, h_data, h_feat, h_step);
                    end
                end
                if (x_ready) begin
                    ev = sel * WPS + idx; ef = idx % N; es = idx / N;
                    checks++;
                    if (x_data !== 32'(ev) || x_feat !== 32'(ef) || x_step !== 32'(es) ||
                        x_last_feat !== (ef == N - 1) || x_last_step !== (es == T - 1)) begin
                        errors++;
                        $display("FAIL word got data=%0d feat=%0d step=%0d lf=%0b ls=%0b exp %0d %0d %0d %0b %0b",
                                 x_data, x_feat, x_step, x_last_feat, x_last_step,
                                 ev, ef, es, ef == N - 1, es == T - 1);
                    end
                    if (ef == N - 1) ack_cd = 3;
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_data = x_data; h_feat = x_feat; h_step = x_step;
                end
            end
            if (!fin && mode == 3 && x_valid === 1'b1 && x_step === 32'd3 && x_feat === 32'd20) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0; x_ready = 1'b0; step_ack = 1'b0; start = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    checks++;
                    if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL abort got valid=%0b busy=%0b done=%0b exp 0 0 0", x_valid, busy, done);
                    end
                    @(negedge clk);
                end
                fin = 1'b1;
            end
            if (!fin && mode == 4 && x_valid === 1'b1 && x_step === 32'd5 && x_feat === 32'd10) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x_data !== 32'd0 ||
                    x_feat !== 32'd0 || x_step !== 32'd0 || x_last_feat !== 1'b0 ||
                    x_last_step !== 1'b0 || mem_addr !== 32'd0) begin
                    errors++;
                    $display("FAIL async_reset got valid=%0b busy=%0b data=%0d feat=%0d step=%0d addr=%0d exp all 0",
                             x_valid, busy, x_data, x_feat, x_step, mem_addr);
                end
                x_ready = 1'b0; step_ack = 1'b0; start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout got words=%0d exp completion", idx);
        end
        x_ready = 1'b0; step_ack = 1'b0; start = 1'b0;
        if (got_done) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL after_done got done=%0b busy=%0b exp 0 0", done, busy);
            end
        end
        words = idx;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sample_sel = 32'd0; abort = 1'b0;
        step_ack = 1'b0; x_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x_data !== 32'd0 ||
            mem_addr !== 32'd0 || x_feat !== 32'd0 || x_step !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%0b busy=%0b done=%0b data=%0d addr=%0d exp all 0",
                     x_valid, busy, done, x_data, mem_addr);
        end
    endtask

    task automatic test_sample(input int sel);
        int w, d;
        drive_sample(sel, 0, w, d);
        checks++;
        if (w != WPS || d != 1) begin
            errors++;
            $display("FAIL sample%0d_count got words=%0d dones=%0d exp %0d 1", sel, w, d, WPS);
        end
    endtask

    task automatic test_ready_toggle();
        int w, d;
        drive_sample(0, 1, w, d);
        checks++;
        if (w != WPS || d != 1) begin
            errors++;
            $display("FAIL toggle_count got words=%0d dones=%0d exp %0d 1", w, d, WPS);
        end
    endtask

    task automatic test_ignored_inputs();
        int w, d;
        drive_sample(1, 2, w, d);
        checks++;
        if (w != WPS || d != 1) begin
            errors++;
            $display("FAIL ignored_count got words=%0d dones=%0d exp %0d 1", w, d, WPS);
        end
    endtask

    task automatic test_bad_sel();
        logic [31:0] sels [3];
        sels[0] = 32'd2; sels[1] = 32'd7; sels[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            sample_sel = sels[i]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) begin
                checks++;
                if (busy !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL bad_sel got busy=%0b valid=%0b done=%0b exp 0 0 0 sel=%0d",
                             busy, x_valid, done, sels[i]);
                end
                @(negedge clk);
            end
        end
        sample_sel = 32'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start got busy=%0b exp 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int w, d;
        drive_sample(1, 3, w, d);
        checks++;
        if (w != 3 * N + 21 || d != 0) begin
            errors++;
            $display("FAIL abort_count got words=%0d dones=%0d exp %0d 0", w, d, 3 * N + 21);
        end
        test_sample(1);
    endtask

    task automatic test_async_reset();
        int w, d;
        drive_sample(0, 4, w, d);
        checks++;
        if (w != 5 * N + 11 || d != 0) begin
            errors++;
            $display("FAIL reset_count got words=%0d dones=%0d exp %0d 0", w, d, 5 * N + 11);
        end
        test_sample(0);
    endtask

    initial begin
        test_reset();
        test_sample(0);
        test_sample(1);
        test_ready_toggle();
        test_ignored_inputs();
        test_bad_sel();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
